// File: rtl/calc_pipe.sv
// calc_pipe: parametrised arithmetic unit with an iterative restoring divider
// and an in-order result FIFO between a valid/stall request side and a
// valid/stall result side.
module calc_pipe #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_W-1:0]     inpA,
    input  logic [DATA_W-1:0]     inpB,
    input  logic [2:0]            inpOpType,
    input  logic                  inpSigned,
    input  logic                  iValid,
    input  logic                  iStall,
    output logic                  oStall,
    output logic                  oValid,
    output logic [2*DATA_W-1:0]   outC,
    output logic [1:0]            oStatus
);

    localparam int RES_W  = 2 * DATA_W;
    localparam int ENT_W  = RES_W + 2;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ITER_W = $clog2(DATA_W) + 1;

    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ITER_W-1:0] LAST_ITER  = ITER_W'(DATA_W - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [CNT_W-1:0]    count;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [ENT_W-1:0]    mem [FIFO_DEPTH];
    logic [ENT_W-1:0]    head;

    logic                accept;
    logic                is_div;
    logic [RES_W-1:0]    ext_a;
    logic [RES_W-1:0]    ext_b;
    logic [RES_W-1:0]    alu_res;
    logic [1:0]          alu_status;

    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;

    logic [DATA_W-1:0]   dvd_q;
    logic [DATA_W-1:0]   dvs;
    logic [DATA_W-1:0]   rem_r;
    logic [ITER_W-1:0]   iter;
    logic                neg_q;
    logic                neg_r;
    logic                op_rem;
    logic                div_zero;
    logic [RES_W-1:0]    saved_a;
    logic [DATA_W:0]     trial;
    logic                ge;
    logic [RES_W-1:0]    q_ext;
    logic [RES_W-1:0]    r_ext;
    logic [RES_W-1:0]    div_res;
    logic [1:0]          div_status;

    logic                wr_en;
    logic                rd_en;
    logic [ENT_W-1:0]    wr_data;

    assign oStall = (state != IDLE) || (count == FULL_COUNT);
    assign accept = iValid && !oStall;
    assign is_div = (inpOpType == 3'd3) || (inpOpType == 3'd4);

    assign ext_a = inpSigned ? {{DATA_W{inpA[DATA_W-1]}}, inpA} : {{DATA_W{1'b0}}, inpA};
    assign ext_b = inpSigned ? {{DATA_W{inpB[DATA_W-1]}}, inpB} : {{DATA_W{1'b0}}, inpB};

    assign a_neg = inpSigned & inpA[DATA_W-1];
    assign b_neg = inpSigned & inpB[DATA_W-1];
    assign mag_a = a_neg ? (DATA_W'(0) - inpA) : inpA;
    assign mag_b = b_neg ? (DATA_W'(0) - inpB) : inpB;

    // Single-cycle ops on the extended operands; 2*DATA_W bits hold every exact result.
    always_comb begin
        alu_res    = '0;
        alu_status = 2'b00;
        case (inpOpType)
            3'd0:    alu_res = ext_a + ext_b;
            3'd1:    alu_res = ext_a - ext_b;
            3'd2:    alu_res = ext_a * ext_b;
            3'd3,
            3'd4:    alu_res = '0;
            default: alu_status = 2'b01;
        endcase
    end

    assign trial = {rem_r, dvd_q[DATA_W-1]};
    assign ge    = (trial >= {1'b0, dvs});
    assign q_ext = {{DATA_W{1'b0}}, dvd_q};
    assign r_ext = {{DATA_W{1'b0}}, rem_r};

    // Apply the latched signs to the unsigned quotient/remainder magnitudes.
    always_comb begin
        div_res    = '0;
        div_status = 2'b00;
        if (div_zero) begin
            div_status = 2'b10;
            div_res    = op_rem ? saved_a : '1;
        end else if (op_rem) begin
            div_res = neg_r ? (RES_W'(0) - r_ext) : r_ext;
        end else begin
            div_res = neg_q ? (RES_W'(0) - q_ext) : q_ext;
        end
    end

    // Divider control: latch magnitudes, iterate once per cycle, then hand off to the FIFO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            dvd_q    <= '0;
            dvs      <= '0;
            rem_r    <= '0;
            iter     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            op_rem   <= 1'b0;
            div_zero <= 1'b0;
            saved_a  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_div) begin
                        dvd_q    <= mag_a;
                        dvs      <= mag_b;
                        rem_r    <= '0;
                        iter     <= '0;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        op_rem   <= (inpOpType == 3'd4);
                        saved_a  <= ext_a;
                        div_zero <= (inpB == '0);
                        state    <= (inpB == '0) ? DONE : DIV;
                    end
                end
                DIV: begin
                    rem_r <= ge ? (trial[DATA_W-1:0] - dvs) : trial[DATA_W-1:0];
                    dvd_q <= {dvd_q[DATA_W-2:0], ge};
                    iter  <= iter + ITER_W'(1);
                    if (iter == LAST_ITER) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign wr_en   = (state == IDLE && accept && !is_div) || (state == DONE);
    assign wr_data = (state == DONE) ? {div_status, div_res} : {alu_status, alu_res};
    assign rd_en   = oValid && !iStall;

    // FIFO bookkeeping; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Result storage; stale contents are masked by oValid so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign head    = mem[rd_ptr];
    assign oValid  = (count != '0);
    assign outC    = oValid ? head[RES_W-1:0] : '0;
    assign oStatus = oValid ? head[ENT_W-1:RES_W] : 2'b00;

endmodule

// File: tb/tb_calc_pipe.sv
// Directed self-checking bench for calc_pipe at DATA_W=8, FIFO_DEPTH=4.
module tb_calc_pipe;

    logic        clk;
    logic        rstn;
    logic [7:0]  inpA;
    logic [7:0]  inpB;
    logic [2:0]  inpOpType;
    logic        inpSigned;
    logic        iValid;
    logic        iStall;
    logic        oStall;
    logic        oValid;
    logic [15:0] outC;
    logic [1:0]  oStatus;

    int testsRun  = 0;
    int failCount = 0;

    calc_pipe #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .inpA      (inpA),
        .inpB      (inpB),
        .inpOpType (inpOpType),
        .inpSigned (inpSigned),
        .iValid    (iValid),
        .iStall    (iStall),
        .oStall    (oStall),
        .oValid    (oValid),
        .outC      (outC),
        .oStatus   (oStatus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present one request and hold it until the accepting edge has passed.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic sgn);
        int  waitCycles;
        logic taken;
        waitCycles = 0;
        taken      = 1'b0;
        inpA       = a;
        inpB       = b;
        inpOpType  = op;
        inpSigned  = sgn;
        iValid     = 1'b1;
        while (!taken && waitCycles < 50) begin
            taken = !oStall;
            tick();
            waitCycles++;
        end
        iValid = 1'b0;
        checkOutput("accept", 32'(taken), 32'd1);
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (oStall && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        int          stallCycles;
        int          issued;
        int          popped;
        int          budget;
        int          stray;
        logic        accepted5;
        logic        takenNow;
        logic [15:0] expQ[$];

        rstn      = 1'b0;
        inpA      = '0;
        inpB      = '0;
        inpOpType = '0;
        inpSigned = 1'b0;
        iValid    = 1'b0;
        iStall    = 1'b0;

        #12;
        checkOutput("reset oValid",  32'(oValid),  32'd0);
        checkOutput("reset oStall",  32'(oStall),  32'd0);
        checkOutput("reset outC",    32'(outC),    32'd0);
        checkOutput("reset oStatus", 32'(oStatus), 32'd0);
        rstn = 1'b1;
        tick();

        applyStimulus(8'd200, 8'd100, 3'd0, 1'b0);
        checkOutput("add oValid",  32'(oValid),  32'd1);
        checkOutput("add outC",    32'(outC),    32'h012C);
        checkOutput("add oStatus", 32'(oStatus), 32'd0);
        tick();
        checkOutput("add popped", 32'(oValid), 32'd0);

        applyStimulus(8'd5, 8'd10, 3'd1, 1'b0);
        checkOutput("sub outC", 32'(outC), 32'hFFFB);
        tick();

        applyStimulus(8'h80, 8'hFF, 3'd2, 1'b1);
        checkOutput("mul signed outC", 32'(outC), 32'h0080);
        tick();
        applyStimulus(8'h80, 8'hFF, 3'd2, 1'b0);
        checkOutput("mul unsigned outC", 32'(outC), 32'h7F80);
        tick();

        applyStimulus(8'd3, 8'd4, 3'd6, 1'b0);
        checkOutput("illegal outC",    32'(outC),    32'h0000);
        checkOutput("illegal oStatus", 32'(oStatus), 32'b01);
        tick();

        applyStimulus(8'd100, 8'd7, 3'd3, 1'b0);
        waitIdle(stallCycles);
        checkOutput("div stall cycles", 32'(stallCycles), 32'd9);
        checkOutput("div oValid",  32'(oValid),  32'd1);
        checkOutput("div outC",    32'(outC),    32'h000E);
        checkOutput("div oStatus", 32'(oStatus), 32'd0);
        tick();

        applyStimulus(8'd100, 8'd7, 3'd4, 1'b0);
        waitIdle(stallCycles);
        checkOutput("rem outC", 32'(outC), 32'h0002);
        tick();

        applyStimulus(8'h9C, 8'd7, 3'd3, 1'b1);
        waitIdle(stallCycles);
        checkOutput("sdiv outC", 32'(outC), 32'hFFF2);
        tick();

        applyStimulus(8'h9C, 8'd7, 3'd4, 1'b1);
        waitIdle(stallCycles);
        checkOutput("srem outC", 32'(outC), 32'hFFFE);
        tick();

        applyStimulus(8'h80, 8'hFF, 3'd3, 1'b1);
        waitIdle(stallCycles);
        checkOutput("min div -1 outC", 32'(outC), 32'h0080);
        tick();

        applyStimulus(8'h80, 8'hFF, 3'd4, 1'b1);
        waitIdle(stallCycles);
        checkOutput("min rem -1 outC", 32'(outC), 32'h0000);
        tick();

        applyStimulus(8'd5, 8'd0, 3'd3, 1'b0);
        waitIdle(stallCycles);
        checkOutput("div0 stall cycles", 32'(stallCycles), 32'd1);
        checkOutput("div0 outC",    32'(outC),    32'hFFFF);
        checkOutput("div0 oStatus", 32'(oStatus), 32'b10);
        tick();

        applyStimulus(8'hFB, 8'd0, 3'd4, 1'b1);
        waitIdle(stallCycles);
        checkOutput("rem0 outC",    32'(outC),    32'hFFFB);
        checkOutput("rem0 oStatus", 32'(oStatus), 32'b10);
        tick();

        // Back-pressure: fill the FIFO while the result side is stalled.
        iStall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            inpA      = 8'(i);
            inpB      = 8'(i);
            inpOpType = 3'd0;
            inpSigned = 1'b0;
            iValid    = 1'b1;
            checkOutput("bp oStall before edge", 32'(oStall), (i == 5) ? 32'd1 : 32'd0);
            tick();
        end
        checkOutput("bp head held", 32'(outC), 32'd2);
        tick();
        checkOutput("bp head still held", 32'(outC),   32'd2);
        checkOutput("bp still full",      32'(oStall), 32'd1);
        iStall    = 1'b0;
        accepted5 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp drain oValid", 32'(oValid), 32'd1);
            checkOutput("bp drain outC",   32'(outC),   32'(2 * (k + 1)));
            if (iValid && !oStall) begin
                accepted5 = 1'b1;
            end
            tick();
            if (accepted5) begin
                iValid = 1'b0;
            end
        end
        checkOutput("bp drained",    32'(oValid),    32'd0);
        checkOutput("bp 5th taken",  32'(accepted5), 32'd1);

        // Steady stream: one push and one pop every cycle.
        for (int i = 1; i <= 6; i++) begin
            inpA      = 8'(10 * i);
            inpB      = 8'(i);
            inpOpType = 3'd0;
            inpSigned = 1'b0;
            iValid    = 1'b1;
            tick();
            checkOutput("stream oValid", 32'(oValid), 32'd1);
            checkOutput("stream outC",   32'(outC),   32'(11 * i));
            checkOutput("stream oStall", 32'(oStall), 32'd0);
        end
        iValid = 1'b0;
        tick();
        checkOutput("stream drained", 32'(oValid), 32'd0);

        // Toggle iStall around a full FIFO and track order with a scoreboard.
        issued    = 0;
        popped    = 0;
        budget    = 0;
        inpA      = 8'd1;
        inpB      = 8'd0;
        inpOpType = 3'd0;
        iValid    = 1'b1;
        while ((issued < 8 || expQ.size() != 0) && budget < 100) begin
            iStall   = (budget < 5) ? 1'b1 : budget[0];
            takenNow = iValid && !oStall;
            if (takenNow) begin
                expQ.push_back(16'(inpA) + 16'(inpB));
                issued++;
            end
            if (oValid && !iStall) begin
                if (expQ.size() == 0) begin
                    checkOutput("toggle spurious pop", 32'(oValid), 32'd0);
                end else begin
                    checkOutput("toggle order", 32'(outC), 32'(expQ.pop_front()));
                end
                popped++;
            end
            tick();
            if (takenNow) begin
                if (issued == 8) begin
                    iValid = 1'b0;
                end else begin
                    inpA = 8'(issued + 1);
                end
            end
            budget++;
        end
        checkOutput("toggle issued", 32'(issued), 32'd8);
        checkOutput("toggle popped", 32'(popped), 32'd8);
        iStall = 1'b0;
        tick();

        // Asynchronous reset in the middle of a division.
        iStall = 1'b1;
        applyStimulus(8'd9, 8'd9, 3'd0, 1'b0);
        applyStimulus(8'd100, 8'd7, 3'd3, 1'b0);
        tick();
        tick();
        tick();
        #3;
        checkOutput("pre-reset oValid", 32'(oValid), 32'd1);
        checkOutput("pre-reset oStall", 32'(oStall), 32'd1);
        rstn = 1'b0;
        #1;
        checkOutput("mid reset oValid",  32'(oValid),  32'd0);
        checkOutput("mid reset oStall",  32'(oStall),  32'd0);
        checkOutput("mid reset outC",    32'(outC),    32'd0);
        checkOutput("mid reset oStatus", 32'(oStatus), 32'd0);
        #2;
        rstn   = 1'b1;
        iStall = 1'b0;
        tick();
        applyStimulus(8'd1, 8'd2, 3'd0, 1'b0);
        checkOutput("post-reset oValid", 32'(oValid), 32'd1);
        checkOutput("post-reset outC",   32'(outC),   32'h0003);
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (oValid) begin
                stray++;
            end
        end
        checkOutput("no stale divide", 32'(stray), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
